// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline register.
// Captures the decode control word, operands, specifiers and extended
// immediate; detects load-use hazards (bubble + decode stall), raises a
// decode flush on a taken jump, and counts load-use bubbles (saturating).
module id_ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        ValidD,
    input  logic        RegWriteD,
    input  logic        MemtoRegD,
    input  logic        MemWriteD,
    input  logic        ALUSrcD,
    input  logic        RegDstD,
    input  logic        JumpD,
    input  logic        MemRead,
    input  logic [1:0]  ALUControlD,
    input  logic [31:0] RD1D,
    input  logic [31:0] RD2D,
    input  logic [4:0]  RsD,
    input  logic [4:0]  RtD,
    input  logic [4:0]  RdD,
    input  logic [15:0] ImmD,
    input  logic [31:0] PCPlus4D,
    input  logic        StallE,
    input  logic        FlushE,
    output logic        ValidE,
    output logic        RegWriteE,
    output logic        MemtoRegE,
    output logic        MemWriteE,
    output logic        ALUSrcE,
    output logic        RegDstE,
    output logic        JumpE,
    output logic        MemReadE,
    output logic [1:0]  ALUControlE,
    output logic [31:0] RD1E,
    output logic [31:0] RD2E,
    output logic [31:0] ImmE,
    output logic [31:0] PCPlus4E,
    output logic [4:0]  RsE,
    output logic [4:0]  RtE,
    output logic [4:0]  RdE,
    output logic        StallD,
    output logic        FlushD,
    output logic [15:0] BubbleCount
);

    // Execute-stage registers
    logic        r_valid_e;
    logic        r_regwrite_e;
    logic        r_memtoreg_e;
    logic        r_memwrite_e;
    logic        r_alusrc_e;
    logic        r_regdst_e;
    logic        r_jump_e;
    logic        r_memread_e;
    logic [1:0]  r_aluctl_e;
    logic [31:0] r_rd1_e;
    logic [31:0] r_rd2_e;
    logic [31:0] r_imm_e;
    logic [31:0] r_pc4_e;
    logic [4:0]  r_rs_e;
    logic [4:0]  r_rt_e;
    logic [4:0]  r_rd_e;
    logic [15:0] r_bubble_count;

    // Combinational decode-side terms
    logic        w_rt_match;
    logic        w_load_use;
    logic        w_stall_d;
    logic        w_flush_d;
    logic        w_bubble;
    logic        w_zero_ext;
    logic [31:0] w_imm_ext;
    logic        w_count_inc;

    // Hazard detection: a valid load in E whose destination (non-r0) is a source in D
    always_comb begin
        w_rt_match = (r_rt_e != 5'd0) && ((r_rt_e == RsD) || (r_rt_e == RtD));
        w_load_use = r_memread_e & r_valid_e & ValidD & w_rt_match;
        w_stall_d  = w_load_use | StallE;
        w_flush_d  = ValidD & JumpD & ~w_stall_d;
        w_bubble   = FlushE | w_load_use;
    end

    // Immediate extension: ANDI-class logic ops zero-extend, everything else sign-extends
    always_comb begin
        w_zero_ext = (ALUControlD == 2'b01) && !JumpD;
        if (w_zero_ext) begin
            w_imm_ext = {16'h0000, ImmD};
        end else begin
            w_imm_ext = {{16{ImmD[15]}}, ImmD};
        end
    end

    // Count only hazard bubbles that actually enter E; a concurrent FlushE still counts once
    assign w_count_inc = w_load_use & ~StallE & (r_bubble_count != 16'hFFFF);

    // Control word register: hold on StallE, zero on bubble, gate side effects when D is empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid_e    <= 1'b0;
            r_regwrite_e <= 1'b0;
            r_memtoreg_e <= 1'b0;
            r_memwrite_e <= 1'b0;
            r_alusrc_e   <= 1'b0;
            r_regdst_e   <= 1'b0;
            r_jump_e     <= 1'b0;
            r_memread_e  <= 1'b0;
            r_aluctl_e   <= 2'b00;
        end else if (StallE) begin
            r_valid_e    <= r_valid_e;
        end else if (w_bubble) begin
            r_valid_e    <= 1'b0;
            r_regwrite_e <= 1'b0;
            r_memtoreg_e <= 1'b0;
            r_memwrite_e <= 1'b0;
            r_alusrc_e   <= 1'b0;
            r_regdst_e   <= 1'b0;
            r_jump_e     <= 1'b0;
            r_memread_e  <= 1'b0;
            r_aluctl_e   <= 2'b00;
        end else begin
            r_valid_e    <= ValidD;
            r_regwrite_e <= RegWriteD & ValidD;
            r_memtoreg_e <= MemtoRegD;
            r_memwrite_e <= MemWriteD & ValidD;
            r_alusrc_e   <= ALUSrcD;
            r_regdst_e   <= RegDstD;
            r_jump_e     <= JumpD & ValidD;
            r_memread_e  <= MemRead & ValidD;
            r_aluctl_e   <= ALUControlD;
        end
    end

    // Data and specifier registers: same hold/bubble/capture priority as the control word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd1_e <= 32'h0;
            r_rd2_e <= 32'h0;
            r_imm_e <= 32'h0;
            r_pc4_e <= 32'h0;
            r_rs_e  <= 5'd0;
            r_rt_e  <= 5'd0;
            r_rd_e  <= 5'd0;
        end else if (StallE) begin
            r_rd1_e <= r_rd1_e;
        end else if (w_bubble) begin
            r_rd1_e <= 32'h0;
            r_rd2_e <= 32'h0;
            r_imm_e <= 32'h0;
            r_pc4_e <= 32'h0;
            r_rs_e  <= 5'd0;
            r_rt_e  <= 5'd0;
            r_rd_e  <= 5'd0;
        end else begin
            r_rd1_e <= RD1D;
            r_rd2_e <= RD2D;
            r_imm_e <= w_imm_ext;
            r_pc4_e <= PCPlus4D;
            r_rs_e  <= RsD;
            r_rt_e  <= RtD;
            r_rd_e  <= RdD;
        end
    end

    // Saturating load-use bubble counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bubble_count <= 16'h0000;
        end else if (w_count_inc) begin
            r_bubble_count <= r_bubble_count + 16'h0001;
        end
    end

    assign ValidE      = r_valid_e;
    assign RegWriteE   = r_regwrite_e;
    assign MemtoRegE   = r_memtoreg_e;
    assign MemWriteE   = r_memwrite_e;
    assign ALUSrcE     = r_alusrc_e;
    assign RegDstE     = r_regdst_e;
    assign JumpE       = r_jump_e;
    assign MemReadE    = r_memread_e;
    assign ALUControlE = r_aluctl_e;
    assign RD1E        = r_rd1_e;
    assign RD2E        = r_rd2_e;
    assign ImmE        = r_imm_e;
    assign PCPlus4E    = r_pc4_e;
    assign RsE         = r_rs_e;
    assign RtE         = r_rt_e;
    assign RdE         = r_rd_e;
    assign StallD      = w_stall_d;
    assign FlushD      = w_flush_d;
    assign BubbleCount = r_bubble_count;

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage: scoreboard of expected E-stage words,
// pushed as D stimulus is driven and popped after each capturing edge.
module tb_id_ex_stage;

    typedef struct packed {
        logic        valid, regwrite, memtoreg, memwrite, alusrc, regdst, jump, memread;
        logic [1:0]  aluctl;
        logic [31:0] rd1, rd2;
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        logic [31:0] pc4;
    } d_t;

    typedef struct packed {
        logic        valid, regwrite, memtoreg, memwrite, alusrc, regdst, jump, memread;
        logic [1:0]  aluctl;
        logic [31:0] rd1, rd2;
        logic [4:0]  rs, rt, rd;
        logic [31:0] imm;
        logic [31:0] pc4;
    } e_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ValidD, RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD, JumpD, MemRead;
    logic [1:0]  ALUControlD;
    logic [31:0] RD1D, RD2D, PCPlus4D;
    logic [4:0]  RsD, RtD, RdD;
    logic [15:0] ImmD;
    logic        StallE, FlushE;
    logic        ValidE, RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, JumpE, MemReadE;
    logic [1:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, ImmE, PCPlus4E;
    logic [4:0]  RsE, RtE, RdE;
    logic        StallD, FlushD;
    logic [15:0] BubbleCount;

    int          checks = 0;
    int          errors = 0;
    e_t          exp_q[$];
    e_t          got, ex, last_e;
    logic [15:0] exp_bc = 16'h0;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .ValidD(ValidD), .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD),
        .MemWriteD(MemWriteD), .ALUSrcD(ALUSrcD), .RegDstD(RegDstD), .JumpD(JumpD),
        .MemRead(MemRead), .ALUControlD(ALUControlD), .RD1D(RD1D), .RD2D(RD2D),
        .RsD(RsD), .RtD(RtD), .RdD(RdD), .ImmD(ImmD), .PCPlus4D(PCPlus4D),
        .StallE(StallE), .FlushE(FlushE), .ValidE(ValidE), .RegWriteE(RegWriteE),
        .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE), .ALUSrcE(ALUSrcE), .RegDstE(RegDstE),
        .JumpE(JumpE), .MemReadE(MemReadE), .ALUControlE(ALUControlE), .RD1E(RD1E),
        .RD2E(RD2E), .ImmE(ImmE), .PCPlus4E(PCPlus4E), .RsE(RsE), .RtE(RtE), .RdE(RdE),
        .StallD(StallD), .FlushD(FlushD), .BubbleCount(BubbleCount)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    function automatic e_t dut_e();
        e_t e;
        e = '{ValidE, RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, JumpE, MemReadE,
              ALUControlE, RD1E, RD2E, RsE, RtE, RdE, ImmE, PCPlus4E};
        return e;
    endfunction

    // Expected E word for a plain capture of d
    function automatic e_t exp_cap(d_t d);
        e_t e;
        e.valid    = d.valid;
        e.regwrite = d.regwrite & d.valid;
        e.memtoreg = d.memtoreg;
        e.memwrite = d.memwrite & d.valid;
        e.alusrc   = d.alusrc;
        e.regdst   = d.regdst;
        e.jump     = d.jump & d.valid;
        e.memread  = d.memread & d.valid;
        e.aluctl   = d.aluctl;
        e.rd1      = d.rd1;
        e.rd2      = d.rd2;
        e.rs       = d.rs;
        e.rt       = d.rt;
        e.rd       = d.rd;
        e.imm      = (d.aluctl == 2'b01 && !d.jump) ? {16'h0000, d.imm} : {{16{d.imm[15]}}, d.imm};
        e.pc4      = d.pc4;
        return e;
    endfunction

    task automatic drive(input d_t d);
        ValidD = d.valid; RegWriteD = d.regwrite; MemtoRegD = d.memtoreg; MemWriteD = d.memwrite;
        ALUSrcD = d.alusrc; RegDstD = d.regdst; JumpD = d.jump; MemRead = d.memread;
        ALUControlD = d.aluctl; RD1D = d.rd1; RD2D = d.rd2; RsD = d.rs; RtD = d.rt; RdD = d.rd;
        ImmD = d.imm; PCPlus4D = d.pc4;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        d_t d;
        d = '0;
        StallE = 0; FlushE = 0;
        drive(d);
        #1;
        got = dut_e(); checks++;
        if (got !== '0 || BubbleCount !== 16'h0 || StallD !== 1'b0 || FlushD !== 1'b0) begin
            errors++;
            $display("FAIL reset_values got=%h bc=%h sd=%b fd=%b exp zero", got, BubbleCount, StallD, FlushD);
        end
        for (int i = 0; i < 3; i++) begin
            d = '1; d.jump = 1'b0; d.rs = 5'(i); d.imm = 16'(i * 3);
            drive(d);
            FlushE = i[0];
            tick();
            got = dut_e(); checks++;
            if (got !== '0 || BubbleCount !== 16'h0) begin
                errors++;
                $display("FAIL reset_hold%0d got=%h bc=%h exp zero", i, got, BubbleCount);
            end
        end
        rst = 0; FlushE = 0;
        d = '0; d.valid = 1; d.regwrite = 1; d.rd1 = 32'hDEADBEEF; d.rd = 5'd5;
        drive(d);
        exp_q.push_back(exp_cap(d));
        tick();
        got = dut_e(); ex = exp_q.pop_front(); checks++; last_e = ex;
        if (got !== ex || RegWriteE !== 1'b1 || RD1E !== 32'hDEADBEEF || RdE !== 5'd5) begin
            errors++;
            $display("FAIL first_capture got=%h exp=%h", got, ex);
        end
    endtask

    task automatic test_load_use();
        d_t ld, use_i;
        ld = '0; ld.valid = 1; ld.memread = 1; ld.regwrite = 1; ld.memtoreg = 1; ld.alusrc = 1;
        ld.rs = 5'd1; ld.rt = 5'd8; ld.imm = 16'h0010; ld.pc4 = 32'h104;
        drive(ld);
        exp_q.push_back(exp_cap(ld));
        tick();
        got = dut_e(); ex = exp_q.pop_front(); checks++;
        if (got !== ex) begin errors++; $display("FAIL lu_load got=%h exp=%h", got, ex); end
        use_i = '0; use_i.valid = 1; use_i.regwrite = 1; use_i.regdst = 1; use_i.aluctl = 2'b10;
        use_i.rs = 5'd8; use_i.rt = 5'd3; use_i.rd = 5'd9; use_i.rd1 = 32'h11; use_i.rd2 = 32'h22;
        use_i.pc4 = 32'h108;
        drive(use_i);
        #1;
        checks++;
        if (StallD !== 1'b1 || FlushD !== 1'b0) begin
            errors++; $display("FAIL lu_stall_d got sd=%b fd=%b exp sd=1 fd=0", StallD, FlushD);
        end
        exp_q.push_back('0);
        exp_bc = exp_bc + 16'h1;
        tick();
        got = dut_e(); ex = exp_q.pop_front(); checks++;
        if (got !== ex || BubbleCount !== exp_bc) begin
            errors++; $display("FAIL lu_bubble got=%h bc=%h exp=%h bc=%h", got, BubbleCount, ex, exp_bc);
        end
        checks++;
        if (StallD !== 1'b0) begin errors++; $display("FAIL lu_stall_clear got=%b exp=0", StallD); end
        exp_q.push_back(exp_cap(use_i));
        tick();
        got = dut_e(); ex = exp_q.pop_front(); checks++;
        if (got !== ex || BubbleCount !== exp_bc) begin
            errors++; $display("FAIL lu_resume got=%h bc=%h exp=%h bc=%h", got, BubbleCount, ex, exp_bc);
        end
    endtask

    task automatic test_load_r0();
        d_t ld, use_i;
        ld = '0; ld.valid = 1; ld.memread = 1; ld.rt = 5'd0; ld.rs = 5'd2;
        drive(ld);
        exp_q.push_back(exp_cap(ld));
        tick();
        got = dut_e(); ex = exp_q.pop_front(); checks++;
        if (got !== ex) begin errors++; $display("FAIL r0_load got=%h exp=%h", got, ex); end
        use_i = '0; use_i.valid = 1; use_i.regwrite = 1; use_i.rs = 5'd0; use_i.rt = 5'd0; use_i.rd = 5'd4;
        drive(use_i);
        #1;
        checks++;
        if (StallD !== 1'b0) begin errors++; $display("FAIL r0_no_stall got=%b exp=0", StallD); end
        exp_q.push_back(exp_cap(use_i));
        tick();
        got = dut_e(); ex = exp_q.pop_front(); checks++;
        if (got !== ex || BubbleCount !== exp_bc) begin
            errors++; $display("FAIL r0_capture got=%h bc=%h exp=%h bc=%h", got, BubbleCount, ex, exp_bc);
        end
    endtask

    task automatic test_imm_ext();
        d_t d;
        logic [31:0] want [3] = '{32'hFFFF8001, 32'h00008001, 32'hFFFF8001};
        for (int i = 0; i < 3; i++) begin
            d = '0; d.valid = 1; d.alusrc = 1; d.imm = 16'h8001; d.rs = 5'd6;
            d.aluctl = (i == 0) ? 2'b00 : 2'b01;
            d.jump = (i == 2);
            drive(d);
            exp_q.push_back(exp_cap(d));
            tick();
            got = dut_e(); ex = exp_q.pop_front(); checks++;
            if (got !== ex || ImmE !== want[i]) begin
                errors++; $display("FAIL imm_ext%0d got imm=%h exp imm=%h", i, ImmE, want[i]);
            end
        end
    endtask

    task automatic test_jump();
        d_t j, j2;
        j = '0; j.valid = 1; j.jump = 1; j.imm = 16'h0040; j.pc4 = 32'h200;
        drive(j);
        #1;
        checks++;
        if (FlushD !== 1'b1 || StallD !== 1'b0) begin
            errors++; $display("FAIL jump_flush_d got fd=%b sd=%b exp fd=1 sd=0", FlushD, StallD);
        end
        exp_q.push_back(exp_cap(j));
        tick();
        got = dut_e(); ex = exp_q.pop_front(); checks++; last_e = ex;
        if (got !== ex || JumpE !== 1'b1) begin errors++; $display("FAIL jump_capture got=%h exp=%h", got, ex); end
        j2 = j; j2.pc4 = 32'h300; j2.rd1 = 32'hCAFE0000;
        drive(j2);
        StallE = 1;
        #1;
        checks++;
        if (FlushD !== 1'b0 || StallD !== 1'b1) begin
            errors++; $display("FAIL jump_stalled_fd got fd=%b sd=%b exp fd=0 sd=1", FlushD, StallD);
        end
        exp_q.push_back(last_e);
        tick();
        got = dut_e(); ex = exp_q.pop_front(); checks++;
        if (got !== ex) begin errors++; $display("FAIL stall_hold got=%h exp=%h", got, ex); end
        StallE = 0;
    endtask

    task automatic test_flush();
        d_t d, ld, use_i, inv;
        d = '0; d.valid = 1; d.regwrite = 1; d.rs = 5'd7; d.rd1 = 32'h77;
        drive(d);
        FlushE = 1;
        exp_q.push_back('0);
        tick();
        got = dut_e(); ex = exp_q.pop_front(); checks++;
        if (got !== ex || BubbleCount !== exp_bc) begin
            errors++; $display("FAIL flush_only got=%h bc=%h exp=%h bc=%h", got, BubbleCount, ex, exp_bc);
        end
        FlushE = 0;
        ld = '0; ld.valid = 1; ld.memread = 1; ld.rt = 5'd12; ld.rs = 5'd1;
        drive(ld);
        exp_q.push_back(exp_cap(ld));
        tick();
        got = dut_e(); ex = exp_q.pop_front(); checks++;
        if (got !== ex) begin errors++; $display("FAIL flush_load got=%h exp=%h", got, ex); end
        use_i = '0; use_i.valid = 1; use_i.rt = 5'd12; use_i.rs = 5'd3;
        drive(use_i);
        FlushE = 1;
        exp_q.push_back('0);
        exp_bc = exp_bc + 16'h1;
        tick();
        got = dut_e(); ex = exp_q.pop_front(); checks++;
        if (got !== ex || BubbleCount !== exp_bc) begin
            errors++; $display("FAIL flush_and_lu got=%h bc=%h exp=%h bc=%h", got, BubbleCount, ex, exp_bc);
        end
        FlushE = 0;
        inv = '1; inv.valid = 0; inv.aluctl = 2'b10; inv.imm = 16'h8123;
        drive(inv);
        exp_q.push_back(exp_cap(inv));
        tick();
        got = dut_e(); ex = exp_q.pop_front(); checks++;
        if (got !== ex || RegWriteE !== 1'b0 || MemtoRegE !== 1'b1 || ImmE !== 32'hFFFF8123) begin
            errors++; $display("FAIL invalid_gating got=%h exp=%h", got, ex);
        end
    endtask

    task automatic test_saturation();
        d_t ld;
        logic [15:0] want [5] = '{16'hFFFC, 16'hFFFD, 16'hFFFE, 16'hFFFF, 16'hFFFF};
        force dut.r_bubble_count = 16'hFFFB;
        #1;
        release dut.r_bubble_count;
        ld = '0; ld.valid = 1; ld.memread = 1; ld.regwrite = 1; ld.rs = 5'd8; ld.rt = 5'd8;
        drive(ld);
        exp_q.push_back(exp_cap(ld));
        tick();
        got = dut_e(); ex = exp_q.pop_front(); checks++;
        if (got !== ex || BubbleCount !== 16'hFFFB) begin
            errors++; $display("FAIL sat_prime got=%h bc=%h exp=%h bc=fffb", got, BubbleCount, ex);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (StallD !== 1'b1) begin errors++; $display("FAIL sat_stall%0d got=%b exp=1", i, StallD); end
            exp_q.push_back('0);
            tick();
            got = dut_e(); ex = exp_q.pop_front(); checks++;
            if (got !== ex || BubbleCount !== want[i]) begin
                errors++; $display("FAIL sat_bubble%0d got=%h bc=%h exp=%h bc=%h", i, got, BubbleCount, ex, want[i]);
            end
            exp_q.push_back(exp_cap(ld));
            tick();
            got = dut_e(); ex = exp_q.pop_front(); checks++;
            if (got !== ex || BubbleCount !== want[i]) begin
                errors++; $display("FAIL sat_capture%0d got=%h bc=%h exp=%h bc=%h", i, got, BubbleCount, ex, want[i]);
            end
        end
        FlushE = 1;
        exp_q.push_back('0);
        tick();
        got = dut_e(); ex = exp_q.pop_front(); checks++;
        if (got !== ex || BubbleCount !== 16'hFFFF) begin
            errors++; $display("FAIL sat_flush_lu got=%h bc=%h exp=%h bc=ffff", got, BubbleCount, ex);
        end
        FlushE = 0;
        exp_q.push_back(exp_cap(ld));
        tick();
        got = dut_e(); ex = exp_q.pop_front(); checks++;
        if (got !== ex || BubbleCount !== 16'hFFFF) begin
            errors++; $display("FAIL sat_single_bubble got=%h bc=%h exp=%h bc=ffff", got, BubbleCount, ex);
        end
    endtask

    task automatic test_async_reset();
        StallE = 1;
        #2;
        rst = 1;
        #1;
        got = dut_e(); checks++;
        if (got !== '0 || BubbleCount !== 16'h0 || StallD !== 1'b1 || FlushD !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got=%h bc=%h sd=%b fd=%b exp zero sd=1 fd=0", got, BubbleCount, StallD, FlushD);
        end
        StallE = 0;
        #1;
        checks++;
        if (StallD !== 1'b0) begin errors++; $display("FAIL reset_stall_d got=%b exp=0", StallD); end
        exp_bc = 16'h0;
        exp_q.delete();
        tick();
        rst = 0;
    endtask

    initial begin
        StallE = 0; FlushE = 0;
        test_reset();
        test_load_use();
        test_load_r0();
        test_imm_ext();
        test_jump();
        test_flush();
        test_saturation();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline register for the 6-stage processor. It captures the decode-stage control word, register operands, register specifiers and immediate into execute-stage copies. It detects load-use hazards and inserts a bubble while stalling fetch/decode, and it raises a decode flush on a taken jump. It also keeps a saturating count of inserted load-use bubbles for performance monitoring.

## Interface
- No parameters; data width fixed at 32, register specifier width at 5.
- clk  in  1  rising-edge clock for all state.
- rst  in  1  asynchronous, active-high reset.
- ValidD  in  1  the decode slot holds a real instruction.
- RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD, JumpD, MemRead  in  1 each  control from the decode control unit.
- ALUControlD  in  2  ALU op class (00 add, 01 and/immediate-logic, 10 R-type funct decode).
- RD1D, RD2D  in  32 each  register-file read data.
- RsD, RtD, RdD  in  5 each  instruction register fields.
- ImmD  in  16  instruction immediate.
- PCPlus4D  in  32  PC+4 of the decode instruction.
- StallE  in  1  downstream hold request; freezes this stage.
- FlushE  in  1  downstream kill request; forces a bubble into E.
- ValidE, RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, JumpE, MemReadE  out  1 each  registered copies.
- ALUControlE  out  2  registered copy.
- RD1E, RD2E, ImmE, PCPlus4E  out  32 each  registered data; ImmE is extended.
- RsE, RtE, RdE  out  5 each  registered specifiers.
- StallD  out  1  combinational; holds PC and the IF/ID register.
- FlushD  out  1  combinational; clears the IF/ID register.
- BubbleCount  out  16  registered saturating load-use bubble counter.

## Operation
- LoadUse = MemReadE & ValidE & ValidD & (RtE != 0) & ((RtE == RsD) | (RtE == RtD)).
- StallD = LoadUse | StallE.
- FlushD = ValidD & JumpD & ~StallD.
- Immediate extension: when ALUControlD == 01 and JumpD == 0, ImmE = {16'b0, ImmD}, zero-extended (ANDI). Otherwise ImmE = {{16{ImmD[15]}}, ImmD}, sign-extended.
- Per-edge update priority, highest first:
  1. rst: all registered outputs go to 0, BubbleCount goes to 0.
  2. StallE = 1: every E register holds its value; BubbleCount holds.
  3. FlushE = 1 or LoadUse = 1: insert a bubble. ValidE and all E control bits go to 0. Data and specifier registers go to 0. The instruction stays in D because StallD = 1 on a load-use, or it is killed upstream on a flush.
  4. Otherwise, capture: every E register takes its D value; ValidE = ValidD.
  5. If ValidD = 0 on a capture, the control bits are still captured, but ValidE = 0 and the stores/writes are gated to 0: RegWriteE = MemWriteE = MemReadE = JumpE = 0.
- BubbleCount increments by 1 on each edge where case 3 occurs with LoadUse = 1 and StallE = 0. It saturates at 16'hFFFF. FlushE-only bubbles are not counted.
- FlushE and LoadUse together: exactly one bubble, counted once.

## Timing
- Latency is one cycle from D inputs to E outputs; throughput is one instruction per cycle when not stalled.
- StallD and FlushD are purely combinational from the current E registers and the current D inputs; there is no registered delay.
- A load-use hazard causes exactly one bubble. On the next cycle the E stage holds the bubble (MemReadE = 0), so LoadUse clears and the held D instruction is captured.
- Reset is asynchronous and takes effect mid-cycle, including during a stall or bubble. Outputs read 0 immediately. StallD and FlushD then evaluate with ValidE = 0, so they depend only on StallE, JumpD and ValidD.
- Reset values: every output is 0, including StallD/FlushD when StallE = 0 and JumpD & ValidD = 0.

## Test plan
- Reset, then hold rst for 3 cycles while the inputs toggle: every E output and BubbleCount stay 0. Release rst, then drive ValidD = 1, RegWriteD = 1, RD1D = 32'hDEADBEEF, RdD = 5. Next edge: RegWriteE = 1, RD1E = 32'hDEADBEEF, RdE = 5.
- Load word in E (MemReadE = 1, RtE = 8), followed by a D instruction with RsD = 8: StallD = 1 in the same cycle. Next edge: all E control = 0 and BubbleCount = 1. One edge later the D instruction is in E and StallD = 0.
- Same as the previous scenario but with RtE = 0: no stall, no bubble, count unchanged.
- ImmD = 16'h8001 with ALUControlD = 00 gives ImmE = 32'hFFFF8001. With ALUControlD = 01 and JumpD = 0, ImmE = 32'h00008001.
- JumpD = 1, ValidD = 1, no stall: FlushD = 1 and JumpE = 1 the next edge. Repeat with StallE = 1: FlushD = 0 and the E registers are unchanged.
- Preload BubbleCount to 16'hFFFE through load-use bubbles, then force 2 more: the count reads 16'hFFFF and stays. Then assert FlushE with LoadUse in the same cycle: a single bubble, count still 16'hFFFF.
